// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types, constants and round-robin pick helper for uart_tx_arb
// Revision : 1.0
// ============================================================================
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      XFER = 2'd2
   } arb_state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;
   localparam int         MAX_REQ = 16;

   // Index of the first set bit at or after ptr, wrapping within nreq lanes.
   // Scanning from the farthest offset down leaves the nearest hit in pick.
   function automatic logic [3:0] rr_pick(input logic [15:0] valid,
                                          input logic [3:0]  ptr,
                                          input logic [4:0]  nreq);
      logic [3:0] pick;
      logic [4:0] idx;
      pick = ptr;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (5'(i) < nreq) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= nreq) idx = idx - nreq;
            if (valid[idx[3:0]]) pick = idx[3:0];
         end
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_idx.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_idx
// Brief    : Combinational round-robin priority selector over NREQ requests
// Revision : 1.0
// ============================================================================
module rr_pick_idx
   import uart_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [15:0] w_valid;
   logic [3:0]  w_ptr;

   always_comb begin
      w_valid = 16'(valid);
      w_ptr   = 4'(ptr);
      idx     = IW'(rr_pick(w_valid, w_ptr, 5'(NREQ)));
      any     = |valid;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Message-level round-robin arbiter sharing one uart TX write port.
//            Define UART_ARB_HDR_EN to prefix each message with {A, gidx}.
// Revision : 1.0
// ============================================================================
module uart_tx_arb
   import uart_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DBIT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DBIT-1:0] req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 tx_full,
   output logic                 wr_uart,
   output logic [DBIT-1:0]      w_data,
   output logic [NREQ-1:0]      grant,
   output logic                 busy
);

   localparam int IW = $clog2(NREQ);

   arb_state_t      r_state;
   arb_state_t      w_next;
   logic [IW-1:0]   r_gidx;
   logic [IW-1:0]   r_rr_ptr;
   logic [IW-1:0]   w_pick;
   logic            w_any;
   logic            w_wr;
   logic            w_accept_last;
   logic [DBIT-1:0] w_lane [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_lane
         assign w_lane[gi] = req_data[gi*DBIT +: DBIT];
      end
   endgenerate

`ifdef UART_ARB_HDR_EN
   logic [7:0] w_hdr;
   assign w_hdr = {HDR_TAG, 4'(r_gidx)};
`endif

   rr_pick_idx #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .valid (req_valid),
      .ptr   (r_rr_ptr),
      .idx   (w_pick),
      .any   (w_any)
   );

   assign w_accept_last = (r_state == XFER) && w_wr && req_last[r_gidx];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_gidx   <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_any) r_gidx <= w_pick;
         if (w_accept_last)
            r_rr_ptr <= (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + IW'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_any) begin
`ifdef UART_ARB_HDR_EN
               w_next = HDR;
`else
               w_next = XFER;
`endif
            end
         end
`ifdef UART_ARB_HDR_EN
         HDR:  if (!tx_full) w_next = XFER;
`endif
         XFER: if (w_accept_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Write strobe depends on live tx_full so a full FIFO is never written.
   always_comb begin
      w_wr      = 1'b0;
      req_ready = '0;
      w_data    = '0;
      grant     = '0;
      busy      = (r_state != IDLE);
      if (busy) grant[r_gidx] = 1'b1;
      case (r_state)
`ifdef UART_ARB_HDR_EN
         HDR: begin
            w_wr = !tx_full;
            if (w_wr) w_data = DBIT'(w_hdr);
         end
`endif
         XFER: begin
            w_wr              = req_valid[r_gidx] & ~tx_full;
            req_ready[r_gidx] = w_wr;
            if (w_wr) w_data = w_lane[r_gidx];
         end
         default: ;
      endcase
   end

   assign wr_uart = w_wr;

endmodule
`default_nettype wire
